// File: rtl/rc4_prga_encryptor_if.sv
// ----------------------------------------------------------------------------
// rc4_prga_encryptor_if
//
// Bundles every non-clock, non-reset signal of rc4_prga_encryptor:
//   start                in  begin encryption (honoured only in IDLE/DONE)
//   s_address_out        out S memory address
//   s_data_out           out S memory write data
//   s_write_enable_out   out S memory write enable
//   s_q_data_in          in  S memory read data (synchronous read)
//   pt_data / pt_valid   in  plaintext byte and its valid flag
//   pt_ready             out plaintext byte consumed this cycle
//   ct_address_out       out ciphertext RAM address
//   ct_data_out          out ciphertext byte
//   ct_write_enable_out  out ciphertext RAM write strobe
//   busy / done          out status
// Optional (RC4_PRGA_KEYSTREAM_OUT_EN defined):
//   keystream_out        out current keystream byte
//   keystream_valid      out high in keystream acceptance cycles
//
// Modport master is the encryptor side, slave is the surrounding system.
// ----------------------------------------------------------------------------
interface rc4_prga_encryptor_if #(
  parameter int CT_AW = 5
);
  logic             start;
  logic [7:0]       s_address_out;
  logic [7:0]       s_data_out;
  logic             s_write_enable_out;
  logic [7:0]       s_q_data_in;
  logic [7:0]       pt_data;
  logic             pt_valid;
  logic             pt_ready;
  logic [CT_AW-1:0] ct_address_out;
  logic [7:0]       ct_data_out;
  logic             ct_write_enable_out;
  logic             busy;
  logic             done;
`ifdef RC4_PRGA_KEYSTREAM_OUT_EN
  logic [7:0]       keystream_out;
  logic             keystream_valid;
`endif

  modport master (
    input  start, s_q_data_in, pt_data, pt_valid,
`ifdef RC4_PRGA_KEYSTREAM_OUT_EN
    output keystream_out, keystream_valid,
`endif
    output s_address_out, s_data_out, s_write_enable_out, pt_ready,
           ct_address_out, ct_data_out, ct_write_enable_out, busy, done
  );

  modport slave (
    output start, s_q_data_in, pt_data, pt_valid,
`ifdef RC4_PRGA_KEYSTREAM_OUT_EN
    input  keystream_out, keystream_valid,
`endif
    input  s_address_out, s_data_out, s_write_enable_out, pt_ready,
           ct_address_out, ct_data_out, ct_write_enable_out, busy, done
  );
endinterface

// File: rtl/rc4_prga_encryptor.sv
// ----------------------------------------------------------------------------
// rc4_prga_encryptor
//
// RC4 PRGA keystream generator and encryptor. Runs the PRGA over a
// key-scheduled permutation held in an external single-port S memory
// (synchronous read, one cycle latency), swapping entries in place, XORs each
// keystream byte with a plaintext byte taken over a valid/ready handshake and
// writes the ciphertext byte k to address k of a MSG_DEP x 8 RAM.
//
// Ports:
//   CLOCK_50  system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       rc4_prga_encryptor_if.master (S memory, plaintext handshake,
//             ciphertext RAM, start/busy/done)
//
// Parameters:
//   MSG_DEP   bytes encrypted per start, 1..256
//   CT_AW     ciphertext RAM address width, 2**CT_AW >= MSG_DEP
//
// Configuration macro:
//   RC4_PRGA_KEYSTREAM_OUT_EN  exposes keystream_out (= f) and keystream_valid.
//
// Every S-memory read takes three states: the address is driven in ADDR_x and
// held in WAIT_x, and the returned byte is captured in CAP_x.
// ----------------------------------------------------------------------------
module rc4_prga_encryptor #(
  parameter int MSG_DEP = 32,
  parameter int CT_AW   = 5
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  rc4_prga_encryptor_if.master  bus
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_I, ST_WAIT_I, ST_CAP_I,
    ST_ADDR_J, ST_WAIT_J, ST_CAP_J,
    ST_WR_I,   ST_WR_J,
    ST_ADDR_F, ST_WAIT_F, ST_CAP_F,
    ST_XOR_WR,
    ST_DONE
  } state_e;

  localparam logic [7:0] K_LAST = 8'(MSG_DEP - 1);

  state_e     state_q, state_d;
  logic [7:0] i_q,  i_d;
  logic [7:0] j_q,  j_d;
  logic [7:0] k_q,  k_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [7:0] f_q,  f_d;

  logic [7:0] f_addr;

  logic [7:0]       s_addr;
  logic [7:0]       s_data;
  logic             s_we;
  logic             pt_ready;
  logic [CT_AW-1:0] ct_addr;
  logic [7:0]       ct_data;
  logic             ct_we;

  // Keystream index: S[i] + S[j], natural 8-bit wrap.
  assign f_addr = si_q + sj_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would create
  // order-dependent simulation that no longer matches the hardware.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      f_q     <= f_d;
    end
  end

  // NOTE: every signal written below gets its default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    si_d     = si_q;
    sj_d     = sj_q;
    f_d      = f_q;
    s_addr   = '0;
    s_data   = '0;
    s_we     = 1'b0;
    pt_ready = 1'b0;
    ct_addr  = '0;
    ct_data  = '0;
    ct_we    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          i_d     = 8'd1;
          j_d     = '0;
          k_d     = '0;
          state_d = ST_ADDR_I;
        end
      end
      ST_ADDR_I: begin
        s_addr  = i_q;
        state_d = ST_WAIT_I;
      end
      ST_WAIT_I: begin
        s_addr  = i_q;
        state_d = ST_CAP_I;
      end
      ST_CAP_I: begin
        si_d    = bus.s_q_data_in;
        j_d     = j_q + bus.s_q_data_in;
        state_d = ST_ADDR_J;
      end
      ST_ADDR_J: begin
        s_addr  = j_q;
        state_d = ST_WAIT_J;
      end
      ST_WAIT_J: begin
        s_addr  = j_q;
        state_d = ST_CAP_J;
      end
      ST_CAP_J: begin
        sj_d    = bus.s_q_data_in;
        state_d = ST_WR_I;
      end
      // Swap S[i] and S[j]. When i == j both writes hit one entry and the
      // second one leaves si, which equals sj, so the swap is still a no-op.
      ST_WR_I: begin
        s_addr  = i_q;
        s_data  = sj_q;
        s_we    = 1'b1;
        state_d = ST_WR_J;
      end
      ST_WR_J: begin
        s_addr  = j_q;
        s_data  = si_q;
        s_we    = 1'b1;
        state_d = ST_ADDR_F;
      end
      ST_ADDR_F: begin
        s_addr  = f_addr;
        state_d = ST_WAIT_F;
      end
      ST_WAIT_F: begin
        s_addr  = f_addr;
        state_d = ST_CAP_F;
      end
      ST_CAP_F: begin
        f_d     = bus.s_q_data_in;
        state_d = ST_XOR_WR;
      end
      // Holds here until the plaintext side offers a byte; the ciphertext
      // write is a single strobe in the acceptance cycle.
      ST_XOR_WR: begin
        if (bus.pt_valid) begin
          pt_ready = 1'b1;
          ct_we    = 1'b1;
          ct_addr  = CT_AW'(k_q);
          ct_data  = f_q ^ bus.pt_data;
          if (k_q == K_LAST) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + 8'd1;
            i_d     = i_q + 8'd1;
            state_d = ST_ADDR_I;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All outputs decode from registered state, so reset clears them at once.
  assign bus.s_address_out       = s_addr;
  assign bus.s_data_out          = s_data;
  assign bus.s_write_enable_out  = s_we;
  assign bus.pt_ready            = pt_ready;
  assign bus.ct_address_out      = ct_addr;
  assign bus.ct_data_out         = ct_data;
  assign bus.ct_write_enable_out = ct_we;
  assign bus.busy                = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done                = (state_q == ST_DONE);

`ifdef RC4_PRGA_KEYSTREAM_OUT_EN
  assign bus.keystream_out       = f_q;
  assign bus.keystream_valid     = ct_we;
`endif

endmodule

// File: tb/tb_rc4_prga_encryptor.sv
// ----------------------------------------------------------------------------
// tb_rc4_prga_encryptor
//
// Self-checking bench for rc4_prga_encryptor (MSG_DEP = 32). The S memory is a
// behavioural synchronous-read RAM; a plain RC4 model (KSA + PRGA on an array)
// gives the expected ciphertext and final permutation, and an arithmetic
// timing model gives the acceptance cycle of every byte from the per-byte
// stall lengths the bench chooses.
// ----------------------------------------------------------------------------
module tb_rc4_prga_encryptor;

  localparam int MSG_DEP = 32;
  localparam int CT_AW   = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rc4_prga_encryptor_if #(.CT_AW(CT_AW)) bus ();

  rc4_prga_encryptor #(.MSG_DEP(MSG_DEP), .CT_AW(CT_AW)) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .bus      (bus)
  );

  // S memory: one-cycle read latency, bulk load from s_init on load_req.
  logic [7:0] s_mem  [256];
  logic [7:0] s_init [256];
  logic       load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
    end else if (bus.s_write_enable_out) begin
      s_mem[bus.s_address_out] <= bus.s_data_out;
    end
    bus.s_q_data_in <= s_mem[bus.s_address_out];
  end

  // Reference model state.
  logic [7:0] ms      [256];
  logic [7:0] pt      [256];
  logic [7:0] exp_ct  [256];
  logic [7:0] ct_obs  [256];
  logic [7:0] ref_ct  [256];
  int         stall_len [256];
  logic [7:0] key     [16];

  logic [7:0] kv_pt [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] kv_ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] id_ct [3] = '{8'h02, 8'h05, 8'h07};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_identity();
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
  endtask

  task automatic model_ksa(input int klen);
    logic [7:0] mj;
    logic [7:0] t;
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    mj = 8'd0;
    for (int x = 0; x < 256; x++) begin
      mj    = mj + ms[x] + key[x % klen];
      t     = ms[x];
      ms[x] = ms[mj];
      ms[mj] = t;
    end
  endtask

  // Standard RC4 PRGA, one fresh (i, j) = (0, 0) per run over the current S.
  task automatic model_prga();
    logic [7:0] mi, mj, t, fa;
    mi = 8'd0;
    mj = 8'd0;
    for (int k = 0; k < MSG_DEP; k++) begin
      mi     = mi + 8'd1;
      mj     = mj + ms[mi];
      t      = ms[mi];
      ms[mi] = ms[mj];
      ms[mj] = t;
      fa     = ms[mi] + ms[mj];
      exp_ct[k] = pt[k] ^ ms[fa];
    end
  endtask

  task automatic load_s();
    for (int x = 0; x < 256; x++) s_init[x] = ms[x];
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic check_s_mem(input string tag);
    int diffs;
    diffs = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== ms[x]) diffs++;
    check(tag, diffs, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {bus.s_address_out, bus.s_data_out, bus.s_write_enable_out,
                bus.pt_ready, bus.ct_address_out, bus.ct_data_out,
                bus.ct_write_enable_out, bus.busy, bus.done}, 0);
  endtask

  // One start-to-done run. Cycle 0 is the cycle start is sampled; byte k is
  // offered 11 cycles after its ADDR_I and accepted stall_len[k] cycles later.
  // glitch_cyc pulses start mid-run; abort_cyc asserts reset mid-run.
  task automatic run_msg(input string name, input int glitch_cyc, input int abort_cyc);
    int acc [256];
    int ent;
    int last;
    int k;
    ent = 12;
    for (int m = 0; m < MSG_DEP; m++) begin
      acc[m] = ent + stall_len[m];
      ent    = acc[m] + 12;
    end
    last = acc[MSG_DEP-1];
    model_prga();

    @(negedge clk);
    bus.start    = 1'b1;
    bus.pt_valid = 1'($urandom_range(0, 1));
    bus.pt_data  = 8'($urandom);
    k = 0;
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      bus.start = (c == glitch_cyc);
      if (c == abort_cyc) begin
        bus.pt_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero({name, "_abort_outputs"});
        for (int r = 0; r < 3; r++) begin
          @(negedge clk);
          check({name, "_abort_no_writes"},
                {bus.ct_write_enable_out, bus.s_write_enable_out, bus.done}, 0);
        end
        rst_n = 1'b1;
        bus.pt_valid = 1'b0;
        bus.start    = 1'b0;
        return;
      end
      if (k < MSG_DEP && c >= acc[k] - stall_len[k] && c < acc[k]) begin
        bus.pt_valid = 1'b0;
        bus.pt_data  = 8'($urandom);
      end else if (k < MSG_DEP && c == acc[k]) begin
        bus.pt_valid = 1'b1;
        bus.pt_data  = pt[k];
      end else begin
        bus.pt_valid = 1'($urandom_range(0, 1));
        bus.pt_data  = 8'($urandom);
      end
      #1;
      if (c == last + 1) begin
        check({name, "_done"}, {bus.done, bus.busy}, 2'b10);
      end else if (k < MSG_DEP && c == acc[k]) begin
        check({name, "_accept"}, {bus.ct_write_enable_out, bus.pt_ready, bus.busy}, 3'b111);
        check({name, "_ct_addr"}, bus.ct_address_out, k);
        check({name, "_ct_data"}, bus.ct_data_out, exp_ct[k]);
`ifdef RC4_PRGA_KEYSTREAM_OUT_EN
        check({name, "_ks_valid"}, bus.keystream_valid, 1);
        check({name, "_ks_out"}, bus.keystream_out, exp_ct[k] ^ pt[k]);
`endif
        ct_obs[k] = bus.ct_data_out;
        k++;
      end else begin
        check({name, "_quiet"},
              {bus.ct_write_enable_out, bus.pt_ready, bus.done, bus.busy}, 4'b0001);
`ifdef RC4_PRGA_KEYSTREAM_OUT_EN
        check({name, "_ks_quiet"}, bus.keystream_valid, 0);
`endif
      end
    end
    bus.start    = 1'b0;
    bus.pt_valid = 1'b0;
    check_s_mem({name, "_s_perm"});
  endtask

  task automatic set_stalls(input int max_stall);
    for (int m = 0; m < 256; m++) stall_len[m] = (max_stall == 0) ? 0 : $urandom_range(0, max_stall);
  endtask

  task automatic set_key_key();
    key[0] = 8'h4B;
    key[1] = 8'h65;
    key[2] = 8'h79;
    model_ksa(3);
  endtask

  initial begin
    int diffs;
    bus.start    = 1'b0;
    bus.pt_valid = 1'b0;
    bus.pt_data  = 8'h00;
    for (int x = 0; x < 16; x++) key[x] = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_outputs_zero("post_reset_outputs");

    // Identity S, all-zero plaintext.
    model_identity();
    load_s();
    for (int x = 0; x < 256; x++) pt[x] = 8'h00;
    set_stalls(0);
    run_msg("identity", 0, 0);
    for (int x = 0; x < 3; x++) check("identity_known_ct", ct_obs[x], id_ct[x]);

    // Continue from the mutated S, random plaintext and stalls, stray start.
    for (int x = 0; x < 256; x++) pt[x] = 8'($urandom);
    set_stalls(3);
    run_msg("continue_glitch", 50, 0);

    // Known vector: key "Key", plaintext "Plaintext".
    set_key_key();
    load_s();
    for (int x = 0; x < 256; x++) pt[x] = 8'($urandom);
    for (int x = 0; x < 9; x++) pt[x] = kv_pt[x];
    set_stalls(0);
    run_msg("key_vector", 0, 0);
    for (int x = 0; x < 9; x++) check("key_vector_known_ct", ct_obs[x], kv_ct[x]);
    for (int x = 0; x < MSG_DEP; x++) ref_ct[x] = ct_obs[x];

    // Same run with a 5-cycle stall at byte 3.
    set_key_key();
    load_s();
    stall_len[3] = 5;
    run_msg("stall5", 0, 0);
    diffs = 0;
    for (int x = 0; x < MSG_DEP; x++) if (ct_obs[x] !== ref_ct[x]) diffs++;
    check("stall5_same_ct", diffs, 0);
    stall_len[3] = 0;

    // Reset in mid-run, then a clean run from a fresh KSA.
    set_key_key();
    load_s();
    run_msg("abort", 0, 100);
    @(negedge clk);
    #1;
    check_outputs_zero("after_abort_idle");
    set_key_key();
    load_s();
    run_msg("after_abort", 0, 0);
    diffs = 0;
    for (int x = 0; x < MSG_DEP; x++) if (ct_obs[x] !== ref_ct[x]) diffs++;
    check("after_abort_same_ct", diffs, 0);

    // Random keys, random plaintext, random stalls.
    for (int r = 0; r < 3; r++) begin
      for (int x = 0; x < 16; x++) key[x] = 8'($urandom);
      model_ksa($urandom_range(1, 16));
      load_s();
      for (int x = 0; x < 256; x++) pt[x] = 8'($urandom);
      set_stalls(4);
      run_msg("random_key", 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rc4_prga_encryptor.md
# rc4_prga_encryptor

RC4 keystream generator and encryptor: the transmit-side counterpart of the decrypt path. Once the S memory holds a key-scheduled permutation, the block runs the RC4 PRGA over it, swapping entries in place. It XORs each keystream byte with a plaintext byte taken over a valid/ready handshake and writes the resulting ciphertext into a MSG_DEP×8 RAM in the same format the ROM reader consumes. It sits on the S-memory mux alongside the shuffle FSMs, and the time machine grants it the S memory for its own state.

## Interface
- MSG_DEP, 32, number of bytes encrypted per start; legal range 1–256.
- CT_AW, 5, ciphertext RAM address width; requires 2^CT_AW ≥ MSG_DEP.

- CLOCK_50  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin encryption; sampled only in IDLE or DONE
- s_address_out  out  8  S memory address
- s_data_out  out  8  S memory write data
- s_write_enable_out  out  1  S memory write enable
- s_q_data_in  in  8  S memory read data (single-port, synchronous read)
- pt_data  in  8  plaintext byte
- pt_valid  in  1  pt_data valid
- pt_ready  out  1  plaintext byte consumed this cycle
- ct_address_out  out  CT_AW  ciphertext RAM address
- ct_data_out  out  8  ciphertext byte
- ct_write_enable_out  out  1  ciphertext RAM write strobe
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  level; high in DONE until next start or reset

## Operation
- Registers:
  - i, j, si, sj, f: 8 bits each.
  - k: byte counter, 0..MSG_DEP-1.
  - All sums are modulo 256 (natural 8-bit wrap).
- On start: i←1, j←0, k←0, done←0; go to ADDR_I.
- States, with outputs (unlisted strobes are 0):
  - IDLE: waits for start.
  - ADDR_I: s_address=i.
  - WAIT_I: s_address=i.
  - CAP_I: si←q, j←j+q.
  - ADDR_J: s_address=j.
  - WAIT_J: s_address=j.
  - CAP_J: sj←q.
  - WR_I: s_address=i, s_data=sj, we=1.
  - WR_J: s_address=j, s_data=si, we=1.
  - ADDR_F: s_address=si+sj.
  - WAIT_F: s_address=si+sj.
  - CAP_F: f←q.
  - XOR_WR: waits for pt_valid. When pt_valid=1:
    - pt_ready=1, ct_write_enable=1, ct_address=k, ct_data=f^pt_data.
    - If k==MSG_DEP-1, go to DONE.
    - Otherwise k←k+1, i←i+1, go to ADDR_I.
  - DONE: done=1. start re-enters ADDR_I with fresh counters.
- S-memory read rule: q is sampled two cycles after the address is first driven (ADDR → WAIT → CAP).
- i==j: WR_I and WR_J hit the same address. The final content is si, which equals sj here, so RC4 semantics hold.
- The S memory is permuted in place. Re-running without a fresh KSA continues from the mutated state, by design.
- start while busy is ignored.
- pt_valid outside XOR_WR is ignored. pt_ready is never high outside XOR_WR.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE; i, j, k, si, sj, f = 0.
- Reset mid-operation: reset_n low forces IDLE and zeroes all outputs asynchronously. No further S or ciphertext writes occur. A partially permuted S memory is left as is.
- Per byte: 12 cycles (ADDR_I through XOR_WR), plus one cycle for every XOR_WR cycle spent with pt_valid=0.
- Start to done: with pt_valid held high, done rises exactly 12·MSG_DEP+1 cycles after the start cycle (384+1 for MSG_DEP=32).
- Ciphertext write for byte k is a single-cycle strobe in its XOR_WR acceptance cycle.

## Configuration
- RC4_PRGA_KEYSTREAM_OUT_EN
  - Defined: adds two outputs, keystream_out[7:0] (=f) and keystream_valid (1 in XOR_WR acceptance cycles). Used for debug and scoreboard tap.
  - Undefined: both ports and their logic are absent. Core behaviour and timing are identical either way.

## Test plan
- Identity S (s[x]=x), plaintext all 0x00, MSG_DEP=32 → ct[0..2]=0x02,0x05,0x07; after byte 1, s[2]=0x03 and s[3]=0x02.
- S loaded from the KSA reference model with key "Key", MSG_DEP=9, plaintext "Plaintext" → ct = BB F3 16 E8 D9 40 AF 0A D3; done high at cycle 109.
- Backpressure: pt_valid low for 5 cycles at k=3 → no ct write and no pt_ready during the stall; ciphertext unchanged vs. no-stall run; done 5 cycles later.
- start pulsed at cycle 50 while busy → ignored; output identical to a run without the extra pulse.
- reset_n low at cycle 100 → all outputs 0 immediately, done=0, no further writes; new start after release → 12·MSG_DEP+1-cycle run completes.
- With RC4_PRGA_KEYSTREAM_OUT_EN, identity S → keystream_out=0x02,0x05,0x07 aligned with keystream_valid and ct_write_enable.
